// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller.
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_B, RUN, DONE} state_t;

  localparam logic SEL_A    = 1'b0;
  localparam logic SEL_B    = 1'b1;
  localparam logic SEL_SUB  = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  localparam int MAX_ITER_DEFAULT = 65535;
  localparam int CW_DEFAULT       = 17;
endpackage

// File: rtl/gcd_controller_if.sv
// Handshake, comparator status and datapath control bundle between the GCD controller and its datapath.
interface gcd_controller_if #(parameter int CW = 17);
  logic          in_valid, in_ready, out_valid, out_ready;
  logic          lt, gt, eq;
  logic          ldA, ldB, sel1, sel2, sel_in;
  logic          busy, timeout;
  logic [CW-1:0] iter_count;

  modport master (
    input  in_valid, out_ready, lt, gt, eq,
    output in_ready, out_valid, ldA, ldB, sel1, sel2, sel_in, busy, timeout, iter_count
  );
  modport slave (
    output in_valid, out_ready, lt, gt, eq,
    input  in_ready, out_valid, ldA, ldB, sel1, sel2, sel_in, busy, timeout, iter_count
  );
endinterface

// File: rtl/gcd_iter_counter.sv
// Clear/increment subtraction counter; tc_next flags the increment that lands on MAX_ITER.
module gcd_iter_counter #(
  parameter int CW       = 17,
  parameter int MAX_ITER = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc_next
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign tc_next = inc && (count == CW'(MAX_ITER - 1));
endmodule

// File: rtl/gcd_controller.sv
// Control FSM for a 16-bit subtractive GCD datapath: operand intake, one subtraction per cycle, bounded run.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  gcd_controller_if.master bus
);
  state_t state;
  logic   timeout_q;
  logic   ld_a, ld_b, s1, s2, s_in, sub, tc_next, clr;

  assign clr = (state == IDLE) && bus.in_valid;

  gcd_iter_counter #(.CW(CW), .MAX_ITER(MAX_ITER)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .inc     (sub),
    .count   (bus.iter_count),
    .tc_next (tc_next)
  );

  // eq wins over gt/lt; no status bit at all is treated as eq.
  always_comb begin
    ld_a = 1'b0;
    ld_b = 1'b0;
    s1   = SEL_A;
    s2   = SEL_B;
    s_in = SEL_SUB;
    sub  = 1'b0;
    case (state)
      IDLE:   if (bus.in_valid) begin ld_a = 1'b1; s_in = SEL_DATA; end
      LOAD_B: if (bus.in_valid) begin ld_b = 1'b1; s_in = SEL_DATA; end
      RUN: begin
        if (!bus.eq && bus.gt) begin
          ld_a = 1'b1; s1 = SEL_A; s2 = SEL_B; sub = 1'b1;
        end else if (!bus.eq && bus.lt) begin
          ld_b = 1'b1; s1 = SEL_B; s2 = SEL_A; sub = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          timeout_q <= 1'b0;
          state     <= LOAD_B;
        end
        LOAD_B: if (bus.in_valid) state <= RUN;
        RUN: begin
          if (!sub) begin
            timeout_q <= 1'b0;
            state     <= DONE;
          end else if (tc_next) begin
            timeout_q <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ldA       = ld_a;
  assign bus.ldB       = ld_b;
  assign bus.sel1      = s1;
  assign bus.sel2      = s2;
  assign bus.sel_in    = s_in;
  assign bus.in_ready  = (state == IDLE) || (state == LOAD_B);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_gcd_controller.sv
// Bench: behavioural 16-bit datapath around the controller plus an arithmetic GCD reference model.
module tb_gcd_controller;
  localparam int MAX_ITER = 16;
  localparam int CW       = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcd_controller_if #(.CW(CW)) bus ();
  gcd_controller #(.MAX_ITER(MAX_ITER), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  logic [15:0] dp_a, dp_b, data_in;
  logic [15:0] mx, my, dnext;
  assign mx    = bus.sel1 ? dp_b : dp_a;
  assign my    = bus.sel2 ? dp_b : dp_a;
  assign dnext = bus.sel_in ? data_in : (mx - my);
  always @(posedge clk) begin
    if (bus.ldA) dp_a <= dnext;
    if (bus.ldB) dp_b <= dnext;
  end
  assign bus.lt = dp_a < dp_b;
  assign bus.gt = dp_a > dp_b;
  assign bus.eq = dp_a == dp_b;

  int n_chk = 0, n_pass = 0;
  int ld_log[$];
  bit chk_en = 0, job_on = 0;
  int exp_res, exp_iter, exp_to;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Euclid by repeated subtraction, stopping after max_it steps.
  task automatic gcd_model(input int a, input int b, input int max_it,
                           output int res, output int iters, output int to);
    iters = 0; to = 0;
    while (a != b) begin
      if (iters == max_it) begin to = 1; break; end
      if (a > b) a = a - b; else b = b - a;
      iters++;
    end
    res = a;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) if (chk_en) begin
    if (bus.out_valid) begin
      check("done_ld", {bus.ldA, bus.ldB}, 0);
      check("done_in_ready", bus.in_ready, 0);
      check("done_busy", bus.busy, 0);
      if (job_on) begin
        check("result", dp_a, exp_res);
        check("iter_count", bus.iter_count, exp_iter);
        check("timeout", bus.timeout, exp_to);
      end
    end
    if (bus.busy) begin
      check("run_in_ready", bus.in_ready, 0);
      check("run_out_valid", bus.out_valid, 0);
      if (bus.ldA || bus.ldB) begin
        check("run_sel_in", bus.sel_in, 0);
        check("run_both_ld", bus.ldA && bus.ldB, 0);
        check("run_sel", {bus.sel1, bus.sel2}, bus.ldA ? 2'b01 : 2'b10);
        ld_log.push_back(bus.ldA ? 1 : 2);
      end
    end
  end

  task automatic load_ab(input int a, input int b, input int gap);
    check("idle_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; data_in = 16'(a);
    tick;
    bus.in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick;
      check("loadb_hold_ready", bus.in_ready, 1);
      check("loadb_hold_busy", bus.busy, 0);
    end
    bus.in_valid = 1'b1; data_in = 16'(b);
    tick;
    bus.in_valid = 1'b0; data_in = 16'hdead;
  endtask

  task automatic run_job(input int a, input int b, input int gap, input int hold);
    int lat;
    gcd_model(a, b, MAX_ITER, exp_res, exp_iter, exp_to);
    ld_log.delete();
    job_on = 1;
    load_ab(a, b, gap);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick; lat++; end
    check("latency", lat, exp_to ? exp_iter : exp_iter + 1);
    check("run_loads", ld_log.size(), exp_iter);
    for (int i = 0; i < hold; i++) begin
      bus.out_ready = 1'b0; bus.in_valid = i[0]; data_in = 16'hbeef;
      tick;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_a_stable", dp_a, exp_res);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    job_on = 0;
    check("idle_out_valid", bus.out_valid, 0);
    check("idle_in_ready2", bus.in_ready, 1);
    check("idle_iter_hold", bus.iter_count, exp_iter);
    check("idle_to_hold", bus.timeout, exp_to);
  endtask

  initial begin
    int r, it, to, n2;
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, it, to, n2;
    bus.in_valid = 0; bus.out_ready = 0; data_in = 0;
    rst_n = 0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ld", {bus.ldA, bus.ldB}, 0);
    check("rst_iter", bus.iter_count, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_sel", {bus.sel1, bus.sel2, bus.sel_in}, 3'b010);
    rst_n = 1;
    tick;

    gcd_model(12, 18, MAX_ITER, r, it, to); check("model_12_18", {r, it, to}, {32'd6, 32'd2, 32'd0});
    gcd_model(48, 36, MAX_ITER, r, it, to); check("model_48_36", {r, it, to}, {32'd12, 32'd3, 32'd0});
    gcd_model(0, 5, MAX_ITER, r, it, to);   check("model_0_5", {r, it, to}, {32'd0, 32'd16, 32'd1});
    gcd_model(7, 7, MAX_ITER, r, it, to);   check("model_7_7", {r, it, to}, {32'd7, 32'd0, 32'd0});
    gcd_model(9, 6, MAX_ITER, r, it, to);   check("model_9_6", {r, it, to}, {32'd3, 32'd2, 32'd0});

    chk_en = 1;
    run_job(12, 18, 0, 0);
    check("seq_12_18", {ld_log[0], ld_log[1]}, {32'd2, 32'd1});
    run_job(7, 7, 0, 0);
    run_job(48, 36, 4, 0);
    run_job(0, 5, 0, 0);
    n2 = 0;
    foreach (ld_log[i]) if (ld_log[i] == 2) n2++;
    check("timeout_ldB_pulses", n2, 16);
    run_job(21, 14, 0, 5);
    run_job(0, 0, 0, 0);

    // Abort a long run asynchronously, between clock edges.
    ld_log.delete();
    load_ab(0, 5, 0);
    tick; tick; tick;
    check("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_ld", {bus.ldA, bus.ldB}, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_iter", bus.iter_count, 0);
    #2 rst_n = 1;
    tick;
    run_job(9, 6, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM that drives the 16-bit subtractive GCD datapath.
- Datapath contract: registers A and B, operand muxes M1/M2, input mux M_data, subtractor, comparator.
- Accepts two operands over a valid/ready input handshake and sequences one subtraction per cycle until the comparator reports equal.
- Presents completion over a valid/ready output handshake.
- Bounds runaway loops (zero operand) with an iteration limit and timeout flag.

Parameters:
- MAX_ITER, 65535: maximum subtractions before forced completion with timeout=1; must be >= 1.
- CW, 17: width of iter_count; must satisfy 2**CW > MAX_ITER.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand word present on datapath data_in.
- in_ready  output  1  controller will accept an operand this cycle.
- out_valid  output  1  result held in datapath A (= B) is valid.
- out_ready  input  1  consumer accepts the result.
- lt  input  1  comparator A<B.
- gt  input  1  comparator A>B.
- eq  input  1  comparator A==B.
- ldA  output  1  load datapath register A.
- ldB  output  1  load datapath register B.
- sel1  output  1  M1 select: 0 = A, 1 = B (subtractor minuend X).
- sel2  output  1  M2 select: 0 = A, 1 = B (subtrahend Y).
- sel_in  output  1  M_data select: 0 = subtractor output, 1 = data_in.
- busy  output  1  high in RUN.
- timeout  output  1  valid with out_valid; 1 = MAX_ITER reached without eq.
- iter_count  output  CW  subtractions performed in the current or last job.

Behaviour:
- States: IDLE (await A), LOAD_B (await B), RUN, DONE.
- Reset (async, rst_n=0): state=IDLE, iter_count=0, timeout=0.
  - out_valid=0, busy=0, ldA=ldB=0, in_ready=1.
  - Reset mid-RUN or mid-DONE aborts immediately. Datapath registers are not reset; stale contents are ignored.
- Default outputs (any cycle not listed below): ldA=0, ldB=0, sel1=0, sel2=1, sel_in=0.
- IDLE: in_ready=1.
  - in_valid=1 => ldA=1, sel_in=1 (Mealy, same cycle), so A captures data_in on this edge.
  - On the same edge: iter_count<=0, timeout<=0, next state LOAD_B.
- LOAD_B: in_ready=1.
  - in_valid=1 => ldB=1, sel_in=1; next state RUN.
  - Otherwise hold indefinitely.
- RUN: in_ready=0, busy=1. lt/gt/eq are evaluated every cycle; they reflect register contents after the previous edge.
  - eq=1 => no load; next state DONE, timeout<=0.
  - gt=1 => ldA=1, sel1=0, sel2=1, sel_in=0 (A<=A-B); iter_count++.
  - lt=1 => ldB=1, sel1=1, sel2=0, sel_in=0 (B<=B-A); iter_count++.
  - If a subtraction makes iter_count reach MAX_ITER => next state DONE, timeout<=1. eq has priority when both conditions apply.
  - Status inputs are one-hot by contract. If none is set, treat as eq.
- Throughput: one subtraction per cycle. out_valid rises (subtractions+1) cycles after the edge that captured B.
- DONE: out_valid=1, in_ready=0, no loads.
  - Datapath A is held, and therefore stable, while out_valid=1.
  - out_ready=1 => next state IDLE. The earliest new A is accepted the cycle after the out handshake.
  - in_valid during DONE or RUN is ignored and not consumed.
- iter_count and timeout hold their values through DONE and IDLE until the next A is accepted.
- Zero operands:
  - (0,0) => eq on the first RUN cycle; result 0, iter_count=0.
  - (0,n>0) => never equal; ends with timeout=1.

Decomposition:
- gcd_pkg holds:
  - state enum {IDLE, LOAD_B, RUN, DONE};
  - select constants SEL_A=0, SEL_B=1, SEL_SUB=0, SEL_DATA=1;
  - default MAX_ITER.
- One sub-module, gcd_iter_counter: CW-bit clear/increment counter with a terminal-count flag at MAX_ITER.

Test Plan:
- (12,18), out_ready=1:
  - control sequence lt then gt then eq: ldB with sel1=1/sel2=0, then ldA with sel1=0/sel2=1;
  - out_valid 3 cycles after the B capture edge; result 6, iter_count=2, timeout=0.
- (7,7) -> eq on the first RUN cycle; out_valid 1 cycle after B capture; iter_count=0, no ldA/ldB during RUN.
- (48,36) with 4 idle cycles between A and B -> LOAD_B holds with in_ready=1; result 12, iter_count=3.
- MAX_ITER=16, (0,5) -> 16 consecutive ldB pulses, then out_valid=1 with timeout=1, iter_count=16.
- Result backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held, in_ready=0, ldA/ldB=0. in_valid pulses are not consumed. Returns to IDLE the edge after out_ready=1.
- rst_n low asynchronously mid-RUN -> out_valid/busy/ldA/ldB drop to 0 without a clock edge, in_ready=1. After release, a new (9,6) completes with result 3, iter_count=2.
